// File: rtl/game_ctrl_if.sv
// rtl/game_ctrl_if.sv - player/event inputs and sequencing outputs of game_ctrl
interface game_ctrl_if;
    logic       btn_start;
    logic       frame_tick;
    logic       hit;
    logic       goal;
    logic       start;
    logic       over;
    logic [1:0] state;
    logic [1:0] lives;
    logic [8:0] time_left;
    logic       won;

    modport master (
        output btn_start, frame_tick, hit, goal,
        input  start, over, state, lives, time_left, won
    );

    modport slave (
        input  btn_start, frame_tick, hit, goal,
        output start, over, state, lives, time_left, won
    );
endinterface

// File: rtl/game_ctrl.sv
// rtl/game_ctrl.sv - game sequencer: button debounce, lives, level timer (GAME_CTRL_TIMER_EN)
module game_ctrl #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int INIT_LIVES      = 3,
    parameter int INIT_TIME       = 300,
    parameter int FRAMES_PER_TICK = 24,
    parameter int DYING_FRAMES    = 60
) (
    input  logic       clk,
    input  logic       rst,
    game_ctrl_if.slave bus
);
    localparam int DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int FR_MAX = (FRAMES_PER_TICK > DYING_FRAMES) ? FRAMES_PER_TICK : DYING_FRAMES;
    localparam int FR_W   = $clog2(FR_MAX + 1);

    localparam logic [DB_W-1:0] DB_LAST    = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [FR_W-1:0] DYING_LAST = FR_W'(DYING_FRAMES - 1);
    localparam logic [1:0]      LIVES_INIT = 2'(INIT_LIVES);
    localparam logic [8:0]      TIME_INIT  = 9'(INIT_TIME);
`ifdef GAME_CTRL_TIMER_EN
    localparam logic [FR_W-1:0] TICK_LAST  = FR_W'(FRAMES_PER_TICK - 1);
`endif

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PLAYING = 2'd1,
        DYING   = 2'd2,
        OVER    = 2'd3
    } state_t;

    state_t          st;
    logic            sync1, sync2, deb, deb_q;
    logic [DB_W-1:0] db_cnt;
    logic [FR_W-1:0] fr_cnt;
    logic            start_r, over_r, won_r;
    logic [1:0]      lives_r;
    logic [8:0]      time_r;
    logic            press, timeout, lose;

    assign press = deb & ~deb_q;
`ifdef GAME_CTRL_TIMER_EN
    assign timeout = (time_r == 9'd0);
`else
    assign timeout = 1'b0;
`endif
    assign lose = bus.hit | timeout;

    // Debounced level only moves after DEBOUNCE_CYCLES uninterrupted disagreeing samples.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1  <= 1'b0;
            sync2  <= 1'b0;
            deb    <= 1'b0;
            deb_q  <= 1'b0;
            db_cnt <= '0;
        end else begin
            sync1 <= bus.btn_start;
            sync2 <= sync1;
            deb_q <= deb;
            if (sync2 == deb) begin
                db_cnt <= '0;
            end else if (db_cnt == DB_LAST) begin
                deb    <= sync2;
                db_cnt <= '0;
            end else begin
                db_cnt <= db_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st      <= IDLE;
            start_r <= 1'b0;
            over_r  <= 1'b0;
            won_r   <= 1'b0;
            lives_r <= 2'd0;
            time_r  <= 9'd0;
            fr_cnt  <= '0;
        end else begin
            start_r <= 1'b0;
            over_r  <= 1'b0;
            case (st)
                IDLE: begin
                    if (press) begin
                        st      <= PLAYING;
                        lives_r <= LIVES_INIT;
                        time_r  <= TIME_INIT;
                        fr_cnt  <= '0;
                        won_r   <= 1'b0;
                        start_r <= 1'b1;
                    end
                end
                PLAYING: begin
                    if (bus.goal) begin
                        st     <= OVER;
                        won_r  <= 1'b1;
                        over_r <= 1'b1;
                    end else if (lose) begin
                        if (lives_r == 2'd1) begin
                            lives_r <= 2'd0;
                            st      <= OVER;
                            won_r   <= 1'b0;
                            over_r  <= 1'b1;
                        end else begin
                            lives_r <= lives_r - 2'd1;
                            st      <= DYING;
                            fr_cnt  <= '0;
                        end
                    end
`ifdef GAME_CTRL_TIMER_EN
                    else if (bus.frame_tick) begin
                        if (fr_cnt == TICK_LAST) begin
                            fr_cnt <= '0;
                            if (time_r != 9'd0) time_r <= time_r - 9'd1;
                        end else begin
                            fr_cnt <= fr_cnt + 1'b1;
                        end
                    end
`endif
                end
                DYING: begin
                    if (bus.frame_tick) begin
                        if (fr_cnt == DYING_LAST) begin
                            st      <= PLAYING;
                            time_r  <= TIME_INIT;
                            fr_cnt  <= '0;
                            start_r <= 1'b1;
                        end else begin
                            fr_cnt <= fr_cnt + 1'b1;
                        end
                    end
                end
                OVER: begin
                    if (press) st <= IDLE;
                end
                default: st <= IDLE;
            endcase
        end
    end

    assign bus.start     = start_r;
    assign bus.over      = over_r;
    assign bus.state     = st;
    assign bus.lives     = lives_r;
    assign bus.time_left = time_r;
    assign bus.won       = won_r;
endmodule

// File: tb/tb_game_ctrl.sv
// tb/tb_game_ctrl.sv - self-checking bench for game_ctrl (directed table plus randomized model check)
module tb_game_ctrl;
    logic clk = 1'b0;
    logic rst_a, rst_b;
    always #5 clk = ~clk;

    game_ctrl_if gif_a ();
    game_ctrl_if gif_b ();

    game_ctrl #(
        .DEBOUNCE_CYCLES(16), .INIT_LIVES(3), .INIT_TIME(300),
        .FRAMES_PER_TICK(24), .DYING_FRAMES(60)
    ) dut_a (.clk(clk), .rst(rst_a), .bus(gif_a));

    localparam int B_DEB = 3, B_LIVES = 2, B_TIME = 3, B_FPT = 1, B_DYING = 3;

    game_ctrl #(
        .DEBOUNCE_CYCLES(B_DEB), .INIT_LIVES(B_LIVES), .INIT_TIME(B_TIME),
        .FRAMES_PER_TICK(B_FPT), .DYING_FRAMES(B_DYING)
    ) dut_b (.clk(clk), .rst(rst_b), .bus(gif_b));

`ifdef GAME_CTRL_TIMER_EN
    localparam bit TIMER = 1'b1;
`else
    localparam bit TIMER = 1'b0;
`endif

    int vectors = 0;
    int errors  = 0;

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    typedef struct {
        bit rst, btn, hit, goal, tick;
        int cycles;
        int st, lv, tl, wn, starts, overs;
    } vec_t;

    function automatic vec_t mk(bit r, bit b, bit h, bit g, bit t, int n,
                                int s, int l, int tl, int w, int ns, int no);
        vec_t v;
        v.rst = r; v.btn = b; v.hit = h; v.goal = g; v.tick = t; v.cycles = n;
        v.st = s; v.lv = l; v.tl = tl; v.wn = w; v.starts = ns; v.overs = no;
        return v;
    endfunction

    // Reference model for dut_b: debounce as "last DEBOUNCE samples all disagree".
    bit m_s1, m_s2, m_deb, m_debq, m_start, m_over;
    bit m_hist[$];
    int m_ph, m_lv, m_tl, m_won, m_fr;

    task automatic model_reset();
        m_s1 = 0; m_s2 = 0; m_deb = 0; m_debq = 0; m_start = 0; m_over = 0;
        m_hist.delete();
        m_ph = 0; m_lv = 0; m_tl = 0; m_won = 0; m_fr = 0;
    endtask

    task automatic model_step(input bit btn, input bit hit, input bit goal, input bit tick);
        bit press, all_diff, old_deb;
        press   = m_deb && !m_debq;
        old_deb = m_deb;
        m_hist.push_back(m_s2);
        if (m_hist.size() > B_DEB) void'(m_hist.pop_front());
        all_diff = (m_hist.size() == B_DEB);
        foreach (m_hist[i]) if (m_hist[i] == old_deb) all_diff = 0;
        if (all_diff) begin
            m_deb = !old_deb;
            m_hist.delete();
        end
        m_debq = old_deb;
        m_s2 = m_s1;
        m_s1 = btn;
        m_start = 0;
        m_over  = 0;
        case (m_ph)
            0: if (press) begin
                m_ph = 1; m_lv = B_LIVES; m_tl = B_TIME; m_fr = 0; m_won = 0; m_start = 1;
            end
            1: begin
                if (goal) begin
                    m_ph = 3; m_won = 1; m_over = 1;
                end else if (hit || (TIMER && m_tl == 0)) begin
                    if (m_lv == 1) begin
                        m_lv = 0; m_ph = 3; m_won = 0; m_over = 1;
                    end else begin
                        m_lv = m_lv - 1; m_ph = 2; m_fr = 0;
                    end
                end else if (TIMER && tick) begin
                    m_fr++;
                    if (m_fr == B_FPT) begin
                        m_fr = 0;
                        if (m_tl > 0) m_tl = m_tl - 1;
                    end
                end
            end
            2: if (tick) begin
                m_fr++;
                if (m_fr == B_DYING) begin
                    m_ph = 1; m_tl = B_TIME; m_fr = 0; m_start = 1;
                end
            end
            default: if (press) m_ph = 0;
        endcase
    endtask

    task automatic drive_a(input bit r, input bit b, input bit h, input bit g, input bit t);
        rst_a = r; gif_a.btn_start = b; gif_a.hit = h; gif_a.goal = g; gif_a.frame_tick = t;
    endtask

    task automatic drive_b(input bit r, input bit b, input bit h, input bit g, input bit t);
        rst_b = r; gif_b.btn_start = b; gif_b.hit = h; gif_b.goal = g; gif_b.frame_tick = t;
    endtask

    vec_t tbl[$];

    initial begin
        tbl.push_back(mk(0, 1, 1, 0, 0,  1, 2, 2, 300, 0, 0, 0)); // hit with 3 lives
        tbl.push_back(mk(0, 1, 0, 0, 1, 60, 1, 2, 300, 0, 1, 0)); // dying pause ends
        tbl.push_back(mk(0, 0, 0, 0, 0, 20, 1, 2, 300, 0, 0, 0)); // release: no event
        tbl.push_back(mk(0, 0, 1, 0, 0,  1, 2, 1, 300, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 1, 60, 1, 1, 300, 0, 1, 0));
        tbl.push_back(mk(0, 0, 1, 1, 0,  1, 3, 1, 300, 1, 0, 1)); // goal beats hit
        tbl.push_back(mk(0, 0, 0, 0, 0,  5, 3, 1, 300, 1, 0, 0)); // OVER holds
        tbl.push_back(mk(0, 1, 0, 0, 0, 20, 0, 1, 300, 1, 0, 0)); // press: OVER->IDLE silently
        tbl.push_back(mk(0, 0, 0, 0, 0, 20, 0, 1, 300, 1, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 0, 10, 0, 1, 300, 1, 0, 0)); // glitch
        tbl.push_back(mk(0, 0, 0, 0, 0, 20, 0, 1, 300, 1, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 0, 20, 1, 3, 300, 0, 1, 0)); // new game
        tbl.push_back(mk(0, 1, 1, 0, 0,  1, 2, 2, 300, 0, 0, 0));
        tbl.push_back(mk(1, 1, 0, 0, 0,  1, 0, 0,   0, 0, 0, 0)); // reset in DYING
        tbl.push_back(mk(0, 1, 0, 0, 0,  5, 0, 0,   0, 0, 0, 0));

        drive_a(1, 0, 0, 0, 0);
        drive_b(1, 0, 0, 0, 0);
        repeat (3) @(posedge clk);
        #1;
        check("a_reset_state", gif_a.state, 0);
        check("a_reset_lives", gif_a.lives, 0);
        check("a_reset_time", gif_a.time_left, 0);
        check("a_reset_won", gif_a.won, 0);
        check("a_reset_start", gif_a.start, 0);
        check("a_reset_over", gif_a.over, 0);

        // Press timing: start registered exactly DEBOUNCE+2 edges after first sample.
        @(negedge clk);
        drive_a(0, 1, 0, 0, 0);
        @(posedge clk);
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk);
            #1;
            check($sformatf("a_start_edge_N+%0d", k), gif_a.start, (k == 18) ? 1 : 0);
        end
        check("a_play_state", gif_a.state, 1);
        check("a_play_lives", gif_a.lives, 3);
        check("a_play_time", gif_a.time_left, 300);

        for (int i = 0; i < tbl.size(); i++) begin
            int ns, no;
            ns = 0; no = 0;
            @(negedge clk);
            drive_a(tbl[i].rst, tbl[i].btn, tbl[i].hit, tbl[i].goal, tbl[i].tick);
            for (int c = 0; c < tbl[i].cycles; c++) begin
                @(posedge clk);
                #1;
                ns += int'(gif_a.start);
                no += int'(gif_a.over);
            end
            check($sformatf("tbl%0d_state", i), gif_a.state, tbl[i].st);
            check($sformatf("tbl%0d_lives", i), gif_a.lives, tbl[i].lv);
            check($sformatf("tbl%0d_time", i), gif_a.time_left, tbl[i].tl);
            check($sformatf("tbl%0d_won", i), gif_a.won, tbl[i].wn);
            check($sformatf("tbl%0d_starts", i), ns, tbl[i].starts);
            check($sformatf("tbl%0d_overs", i), no, tbl[i].overs);
        end

        // Small instance: lose a life, then let the countdown expire on the last life.
        @(negedge clk);
        drive_b(0, 1, 0, 0, 0);
        begin
            int waited;
            waited = 0;
            while (gif_b.state != 2'd1 && waited < 20) begin
                @(posedge clk);
                #1;
                waited++;
            end
            check("b_start_reached", gif_b.state, 1);
        end
        @(negedge clk);
        drive_b(0, 1, 1, 0, 0);
        @(posedge clk);
        #1;
        check("b_hit_lives", gif_b.lives, 1);
        check("b_hit_state", gif_b.state, 2);
        @(negedge clk);
        drive_b(0, 1, 0, 0, 1);
        repeat (B_DYING) @(posedge clk);
        #1;
        check("b_dying_exit", gif_b.state, 1);
        check("b_dying_start", gif_b.start, 1);
        check("b_reload_time", gif_b.time_left, B_TIME);
`ifdef GAME_CTRL_TIMER_EN
        for (int k = B_TIME - 1; k >= 0; k--) begin
            @(posedge clk);
            #1;
            check($sformatf("b_countdown_%0d", k), gif_b.time_left, k);
        end
        @(negedge clk);
        drive_b(0, 1, 0, 0, 0);
        @(posedge clk);
        #1;
        check("b_timeout_state", gif_b.state, 3);
        check("b_timeout_won", gif_b.won, 0);
        check("b_timeout_lives", gif_b.lives, 0);
        check("b_timeout_over", gif_b.over, 1);
        @(posedge clk);
        #1;
        check("b_over_once", gif_b.over, 0);
`else
        repeat (6) @(posedge clk);
        #1;
        check("b_no_countdown_time", gif_b.time_left, B_TIME);
        check("b_no_timeout_state", gif_b.state, 1);
`endif

        // Randomized run of the small instance against the reference model.
        @(negedge clk);
        drive_b(1, 0, 0, 0, 0);
        @(posedge clk);
        model_reset();
        begin
            bit btn, r, h, g, t;
            int act, exp;
            btn = 0;
            for (int cyc = 0; cyc < 4000; cyc++) begin
                @(negedge clk);
                if ($urandom_range(0, 7) == 0) btn = !btn;
                r = ($urandom_range(0, 599) == 0);
                h = ($urandom_range(0, 24) == 0);
                g = ($urandom_range(0, 79) == 0);
                t = ($urandom_range(0, 2) == 0);
                drive_b(r, btn, h, g, t);
                @(posedge clk);
                if (r) model_reset();
                else model_step(btn, h, g, t);
                #1;
                act = int'({gif_b.start, gif_b.over, gif_b.state, gif_b.lives,
                            gif_b.time_left, gif_b.won});
                exp = int'({m_start, m_over, 2'(m_ph), 2'(m_lv), 9'(m_tl), 1'(m_won)});
                check($sformatf("rand_cycle_%0d", cyc), act, exp);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
